// File: rtl/perf_monitor.sv
// Performance monitor: a cycle counter plus NUM_CH event counters that run
// over a measurement window. The window opens on start and closes on the
// CPU's done_in or on a watchdog limit. Counters saturate or wrap according
// to SAT_MODE, and a registered readout mux exposes any counter at any time.
module perf_monitor #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 1
) (
  input  logic                         CLOCK_50,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         done_in,
  input  logic [NUM_CH-1:0]            event_in,
  input  logic [CNT_W-1:0]             timeout_limit,
  input  logic [$clog2(NUM_CH+1)-1:0]  rd_sel,
  output logic [CNT_W-1:0]             rd_data,
  output logic [CNT_W-1:0]             cycle_count,
  output logic                         busy,
  output logic                         done,
  output logic                         timed_out,
  output logic [NUM_CH:0]              overflow
);

  localparam int SEL_W = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] ch_cnt [NUM_CH];
  logic [CNT_W-1:0] ch_inc [NUM_CH];
  logic [CNT_W-1:0] cycle_inc;
  logic [CNT_W-1:0] rd_next;
  logic             timeout_hit;

  // Counter step: an all-ones counter either sticks there or rolls over to zero.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if (&v) return (SAT_MODE != 0) ? v : '0;
    return v + CNT_W'(1);
  endfunction

  // Post-increment values, the watchdog compare and the readout mux.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    rd_next   = '0;
    cycle_inc = bump(cycle_count);
    for (int i = 0; i < NUM_CH; i++) begin
      ch_inc[i] = bump(ch_cnt[i]);
      if (rd_sel == SEL_W'(i)) rd_next = ch_cnt[i];
    end
    if (rd_sel == SEL_W'(NUM_CH)) rd_next = cycle_count;
    // The limit is compared live against the post-increment count. Equality
    // is deliberate: a limit already passed does not fire until the count
    // comes back round to it.
    timeout_hit = (timeout_limit != '0) && (cycle_inc == timeout_limit);
  end

  // Window FSM together with the counters, the flags and the readout register.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side reads the value from before this edge.
    if (rst) begin
      state       <= IDLE;
      rd_data     <= '0;
      cycle_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      overflow    <= '0;
      // NOTE: the counter array is cleared element by element on reset,
      // because all counters must read zero straight after reset.
      for (int i = 0; i < NUM_CH; i++) ch_cnt[i] <= '0;
    end else begin
      rd_data <= rd_next;
      done    <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            cycle_count <= '0;
            timed_out   <= 1'b0;
            overflow    <= '0;
            for (int i = 0; i < NUM_CH; i++) ch_cnt[i] <= '0;
          end
        end
        RUN: begin
          // The cycle that ends the window is still counted.
          cycle_count <= cycle_inc;
          if (&cycle_count) overflow[NUM_CH] <= 1'b1;
          for (int i = 0; i < NUM_CH; i++) begin
            if (event_in[i]) begin
              ch_cnt[i] <= ch_inc[i];
              if (&ch_cnt[i]) overflow[i] <= 1'b1;
            end
          end
          // done_in has priority over the watchdog.
          if (done_in) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            timed_out <= 1'b0;
          end else if (timeout_hit) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            timed_out <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor. It drives three instances from the same
// stimulus: the default configuration, plus two 8-bit copies (saturating and
// wrapping) that are used for the overflow cases.
module tb_perf_monitor;

  logic        clk = 1'b0;
  logic        rst, start, done_in;
  logic [3:0]  event_in;
  logic [31:0] timeout_limit;
  logic [2:0]  rd_sel;

  logic [31:0] rd_data, cycle_count;
  logic        busy, done, timed_out;
  logic [4:0]  overflow;

  logic [7:0]  tl8;
  logic [7:0]  s_rd_data, s_cycle_count, w_rd_data, w_cycle_count;
  logic        s_busy, s_done, s_timed_out, w_busy, w_done, w_timed_out;
  logic [4:0]  s_overflow, w_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign tl8 = timeout_limit[7:0];

  perf_monitor #(.NUM_CH(4), .CNT_W(32), .SAT_MODE(1)) u_dut (
    .CLOCK_50(clk), .rst(rst), .start(start), .done_in(done_in),
    .event_in(event_in), .timeout_limit(timeout_limit), .rd_sel(rd_sel),
    .rd_data(rd_data), .cycle_count(cycle_count), .busy(busy), .done(done),
    .timed_out(timed_out), .overflow(overflow)
  );

  perf_monitor #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(1)) u_sat (
    .CLOCK_50(clk), .rst(rst), .start(start), .done_in(done_in),
    .event_in(event_in), .timeout_limit(tl8), .rd_sel(rd_sel),
    .rd_data(s_rd_data), .cycle_count(s_cycle_count), .busy(s_busy), .done(s_done),
    .timed_out(s_timed_out), .overflow(s_overflow)
  );

  perf_monitor #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(0)) u_wrap (
    .CLOCK_50(clk), .rst(rst), .start(start), .done_in(done_in),
    .event_in(event_in), .timeout_limit(tl8), .rd_sel(rd_sel),
    .rd_data(w_rd_data), .cycle_count(w_cycle_count), .busy(w_busy), .done(w_done),
    .timed_out(w_timed_out), .overflow(w_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One rising edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; done_in = 1'b0; event_in = '0;
    timeout_limit = '0; rd_sel = '0;
    tick(2);
    check("rst_cycle", cycle_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_to", timed_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rd", rd_data, 0);
    rst = 1'b0;

    // Basic window: 10 RUN cycles with event 0, done_in on the 10th.
    start = 1'b1; tick(); start = 1'b0;
    check("basic_busy", busy, 1);
    check("basic_cyc0", cycle_count, 0);
    event_in = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) done_in = 1'b1;
      tick();
      if (k < 10) check("basic_nodone", done, 0);
    end
    done_in = 1'b0; event_in = 4'b1111;   // ignored in DONE
    check("basic_done", done, 1);
    check("basic_busy_off", busy, 0);
    check("basic_cyc", cycle_count, 10);
    check("basic_to", timed_out, 0);
    rd_sel = 3'd0; tick();
    check("basic_done_pulse", done, 0);
    check("rd_ch0", rd_data, 10);
    rd_sel = 3'd1; tick(); check("rd_ch1", rd_data, 0);
    rd_sel = 3'd3; tick(); check("rd_ch3", rd_data, 0);
    rd_sel = 3'd4; tick(); check("rd_cyc", rd_data, 10);
    rd_sel = 3'd5; tick(); check("rd_oob", rd_data, 0);
    rd_sel = 3'd0; tick(); check("rd_ch0_hold", rd_data, 10);
    check("hold_cyc", cycle_count, 10);
    event_in = '0;

    // Watchdog expiry at limit 5.
    timeout_limit = 32'd5;
    start = 1'b1; tick(); start = 1'b0;
    tick(4);
    check("wd_busy4", busy, 1);
    tick();
    check("wd_done", done, 1);
    check("wd_to", timed_out, 1);
    check("wd_cyc", cycle_count, 5);
    check("wd_busy", busy, 0);

    // Restart from DONE clears timed_out; done_in and timeout in the same cycle.
    start = 1'b1; tick(); start = 1'b0;
    check("rs_busy", busy, 1);
    check("rs_to", timed_out, 0);
    check("rs_cyc", cycle_count, 0);
    tick(4);
    done_in = 1'b1; tick(); done_in = 1'b0;
    check("tie_done", done, 1);
    check("tie_to", timed_out, 0);
    check("tie_cyc", cycle_count, 5);
    timeout_limit = '0;

    // start pulses during RUN are ignored.
    start = 1'b1; tick(); start = 1'b0;
    event_in = 4'b0010;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    done_in = 1'b1; tick(); done_in = 1'b0;
    event_in = '0;
    check("srun_cyc", cycle_count, 4);
    rd_sel = 3'd1; tick(); check("srun_ch1", rd_data, 4);

    // Reset in RUN cycle 3 beats start/event_in; then done_in is ignored in IDLE.
    start = 1'b1; tick(); start = 1'b0;
    event_in = 4'b0001; rd_sel = 3'd4;
    tick(2);
    rst = 1'b1; start = 1'b1; tick();
    rst = 1'b0; start = 1'b0;
    check("mrst_cyc", cycle_count, 0);
    check("mrst_busy", busy, 0);
    check("mrst_rd", rd_data, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_to", timed_out, 0);
    done_in = 1'b1; tick(); done_in = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(2);
    done_in = 1'b1; tick(); done_in = 1'b0;
    event_in = '0;
    check("fresh_cyc", cycle_count, 3);
    rd_sel = 3'd0; tick(); check("fresh_ch0", rd_data, 3);

    // Overflow: 260 events on channel 2, then a closing cycle without events.
    start = 1'b1; tick(); start = 1'b0;
    event_in = 4'b0100;
    tick(260);
    event_in = '0; done_in = 1'b1; tick(); done_in = 1'b0;
    rd_sel = 3'd2; tick();
    check("ovf_main_ch2", rd_data, 260);
    check("ovf_main_flags", overflow, 0);
    check("ovf_main_cyc", cycle_count, 261);
    check("ovf_sat_ch2", s_rd_data, 255);
    check("ovf_sat_flags", s_overflow, 5'b10100);
    check("ovf_sat_cyc", s_cycle_count, 255);
    check("ovf_wrap_ch2", w_rd_data, 4);
    check("ovf_wrap_flags", w_overflow, 5'b10100);
    check("ovf_wrap_cyc", w_cycle_count, 5);
    tick(2);
    check("ovf_sticky", w_overflow, 5'b10100);
    start = 1'b1; tick(); start = 1'b0;
    check("ovf_clear", w_overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of event counter channels, 1..16.
REQ-002 SHALL have parameter CNT_W, default 32: width of every counter, 8..64.
REQ-003 SHALL have parameter SAT_MODE, default 1: 1 = counters saturate at all-ones; 0 = counters wrap.
REQ-004 SHALL have the following ports:
- CLOCK_50 in 1: sole clock, rising edge.
- rst in 1: reset; synchronous and active-high.
- start in 1: begin measurement window.
- done_in in 1: program-end indication from the CPU.
- event_in in NUM_CH: per-channel increment strobes, e.g. instruction retired, stall, load, store.
- timeout_limit in CNT_W: watchdog limit in cycles; 0 disables the watchdog.
- rd_sel in $clog2(NUM_CH+1): readout select.
- rd_data out CNT_W: registered readout.
- cycle_count out CNT_W: live cycle counter.
- busy out 1: high in RUN.
- done out 1: one-cycle pulse on entry to DONE.
- timed_out out 1: window ended by the watchdog.
- overflow out NUM_CH+1: sticky overflow flags; bit NUM_CH is the cycle counter.

Function
REQ-005 SHALL implement FSM states IDLE, RUN and DONE.
REQ-006 IDLE: start=1 -> RUN; cycle_count, all channel counters, overflow and timed_out clear at that edge. done_in SHALL be ignored in IDLE.
REQ-007 RUN, every cycle: cycle_count increments by 1; counter i increments by 1 when event_in[i]=1; the cycle in which done_in or the timeout is detected SHALL still be counted.
REQ-008 RUN: done_in=1 -> DONE with timed_out=0.
REQ-009 RUN: timeout_limit!=0 and the post-increment cycle_count equals timeout_limit -> DONE with timed_out=1.
REQ-010 RUN: if done_in and timeout occur in the same cycle, done_in SHALL win and timed_out SHALL be 0.
REQ-011 RUN: start SHALL be ignored.
REQ-012 DONE: all counters hold; event_in ignored; start=1 -> clear exactly as in IDLE, then RUN.
REQ-013 done SHALL pulse high for exactly the first cycle of DONE.
REQ-014 busy SHALL be high exactly while in RUN.
REQ-015 Overflow with SAT_MODE=1: a counter at all-ones SHALL stay at all-ones on further increments and set its overflow bit.
REQ-016 Overflow with SAT_MODE=0: a counter at all-ones SHALL wrap to 0 and set its overflow bit.
REQ-017 Overflow bits SHALL be sticky until the next window clear or reset.
REQ-018 rd_data SHALL show the value selected on the previous cycle (1-cycle latency):
- rd_sel<NUM_CH -> channel counter.
- rd_sel=NUM_CH -> cycle_count.
- rd_sel>NUM_CH -> 0.
REQ-019 rd_data readout SHALL be available in every state and SHALL NOT disturb counting.
REQ-020 timeout_limit SHALL be sampled live each cycle; a limit already below cycle_count SHALL NOT trigger the watchdog until wrap (SAT_MODE=0) or never (SAT_MODE=1).

Reset
REQ-021 rst=1 at a rising edge SHALL force IDLE and clear all outputs to 0: rd_data, cycle_count, busy, done, timed_out, overflow and all counters.
REQ-022 rst SHALL take priority over start, done_in and event_in in every state, including mid-RUN.
REQ-023 The first edge after rst deasserts SHALL behave as IDLE.

Verification
REQ-024 Basic window (NUM_CH=4, CNT_W=32): start, then 10 RUN cycles with event_in=4'b0001 each cycle, done_in on the 10th cycle -> cycle_count=10, ch0=10, ch1..3=0, done pulses once, timed_out=0.
REQ-025 Watchdog: timeout_limit=5, start, done_in never asserted -> DONE after 5 RUN cycles, cycle_count=5, timed_out=1; a repeat with done_in in cycle 5 gives timed_out=0.
REQ-026 Overflow (CNT_W=8): event_in[2] high for 260 cycles -> SAT_MODE=1 gives ch2=255 and overflow[2]=1; SAT_MODE=0 gives ch2=4 and overflow[2]=1.
REQ-027 Readout: after the REQ-024 window, rd_sel=0 -> rd_data=10 one cycle later; rd_sel=4 -> 10; rd_sel=5 -> 0.
REQ-028 Reset mid-RUN: rst at RUN cycle 3 -> next cycle IDLE with all outputs 0; a following start produces a fresh count from 0.
REQ-029 Restart from DONE: start while in DONE -> counters and timed_out clear, busy=1 next cycle; start pulses during RUN leave the counts unchanged.
